// File: rtl/pipeline_scheduler_if.sv
// Client/pipeline bundle shared by the scheduler (slave) and whoever drives it (master).
// Signal names keep their i_/o_ direction as seen from the scheduler.
interface pipeline_scheduler_if #(
  parameter int p_width      = 32,
  parameter int p_requesters = 4
);
  localparam int IdW = $clog2(p_requesters);

  logic [p_requesters-1:0]         i_req;
  logic [p_requesters*p_width-1:0] i_req_data;
  logic [p_requesters-1:0]         o_gnt;
  logic                            o_issue_valid;
  logic [p_width-1:0]              o_issue_data;
  logic [p_width-1:0]              i_pipe_data;
  logic                            o_resp_valid;
  logic [IdW-1:0]                  o_resp_id;
  logic [p_width-1:0]              o_resp_data;
  logic                            i_flush;
  logic                            o_busy;

  modport slave (
    input  i_req, i_req_data, i_pipe_data, i_flush,
    output o_gnt, o_issue_valid, o_issue_data, o_resp_valid, o_resp_id, o_resp_data, o_busy
  );

  modport master (
    output i_req, i_req_data, i_pipe_data, i_flush,
    input  o_gnt, o_issue_valid, o_issue_data, o_resp_valid, o_resp_id, o_resp_data, o_busy
  );
endinterface

// File: rtl/pipeline_scheduler.sv
// Round-robin front end for a fixed-latency, non-stallable pipeline shared by several clients.
// A shadow tag pipe remembers which client owns each in-flight word; flush drops them all.
module pipeline_scheduler #(
  parameter int p_width           = 32,
  parameter int p_stages          = 8,
  parameter int p_requesters      = 4,
  parameter int p_max_outstanding = 4
) (
  input logic                  i_clk,
  input logic                  i_rst,
  pipeline_scheduler_if.slave  bus
);
  localparam int IdW = $clog2(p_requesters);
  localparam int CntW = $clog2(p_max_outstanding + 1);

  logic [IdW-1:0]        ptr_q;
  logic                  issueValid_q;
  logic [IdW-1:0]        issueId_q;
  logic [p_width-1:0]    issueData_q;
  logic [p_stages-1:0]   tagValid_q;
  logic [IdW-1:0]        tagId_q [p_stages];
  logic [CntW-1:0]       cnt_q [p_requesters];

  logic [p_requesters-1:0] elig;
  logic [p_requesters-1:0] gnt_d;
  logic                    gntAny;
  logic [IdW-1:0]          gntId;
  logic                    respValid;
  logic [IdW-1:0]          respId;

  assign respValid = tagValid_q[p_stages-1];
  assign respId    = tagId_q[p_stages-1];

  // Reset and flush both suppress eligibility so nothing is granted in those cycles.
  always_comb begin
    for (int n = 0; n < p_requesters; n++) begin
      elig[n] = bus.i_req[n] && (cnt_q[n] < CntW'(p_max_outstanding)) && !bus.i_flush && !i_rst;
    end
  end

  always_comb begin
    gnt_d  = '0;
    gntAny = 1'b0;
    gntId  = '0;
    for (int k = 0; k < p_requesters; k++) begin
      if (!gntAny && elig[(int'(ptr_q) + k) % p_requesters]) begin
        gntAny = 1'b1;
        gntId  = IdW'((int'(ptr_q) + k) % p_requesters);
        gnt_d[(int'(ptr_q) + k) % p_requesters] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q        <= '0;
      issueValid_q <= 1'b0;
      issueId_q    <= '0;
      issueData_q  <= '0;
      tagValid_q   <= '0;
      for (int s = 0; s < p_stages; s++) tagId_q[s] <= '0;
      for (int n = 0; n < p_requesters; n++) cnt_q[n] <= '0;
    end else if (bus.i_flush) begin
      // The word sitting in the issue register still reaches the external pipe, but its tag dies here.
      issueValid_q <= 1'b0;
      tagValid_q   <= '0;
      for (int n = 0; n < p_requesters; n++) cnt_q[n] <= '0;
    end else begin
      issueValid_q <= gntAny;
      if (gntAny) begin
        ptr_q       <= IdW'((int'(gntId) + 1) % p_requesters);
        issueId_q   <= gntId;
        issueData_q <= bus.i_req_data[int'(gntId)*p_width +: p_width];
      end
      tagValid_q[0] <= issueValid_q;
      tagId_q[0]    <= issueId_q;
      for (int s = 1; s < p_stages; s++) begin
        tagValid_q[s] <= tagValid_q[s-1];
        tagId_q[s]    <= tagId_q[s-1];
      end
      for (int n = 0; n < p_requesters; n++) begin
        if (gnt_d[n] && !(respValid && respId == IdW'(n))) begin
          cnt_q[n] <= cnt_q[n] + CntW'(1);
        end else if (!gnt_d[n] && respValid && respId == IdW'(n) && cnt_q[n] != '0) begin
          cnt_q[n] <= cnt_q[n] - CntW'(1);
        end
      end
    end
  end

  assign bus.o_gnt         = gnt_d;
  assign bus.o_issue_valid = issueValid_q;
  assign bus.o_issue_data  = issueData_q;
  assign bus.o_resp_valid  = respValid;
  assign bus.o_resp_id     = respId;
  assign bus.o_resp_data   = bus.i_pipe_data;
  assign bus.o_busy        = (|tagValid_q) | issueValid_q;
endmodule

// File: tb/tb_pipeline_scheduler.sv
// Directed bench for pipeline_scheduler with an 8-stage delay line standing in for the pipeline.
module tb_pipeline_scheduler;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  pipeline_scheduler_if #(.p_width(32), .p_requesters(4)) bus ();

  pipeline_scheduler #(
    .p_width(32), .p_stages(8), .p_requesters(4), .p_max_outstanding(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External pipeline model: issue data reappears 8 cycles after it was issued.
  logic [31:0] pipeQ [8];
  always @(posedge clk) begin
    pipeQ[0] <= bus.o_issue_data;
    for (int i = 1; i < 8; i++) pipeQ[i] <= pipeQ[i-1];
  end
  assign bus.i_pipe_data = pipeQ[7];

  localparam logic [127:0] DataA5 = {32'h0, 32'hA5, 32'h0, 32'h0};
  localparam logic [127:0] DataRR = {32'h103, 32'h102, 32'h101, 32'h100};
  localparam logic [127:0] Data41 = {32'h0, 32'h0, 32'h41, 32'h0};

  // Drive one cycle's inputs just after the edge, then wait for the falling edge to observe.
  task automatic applyStimulus(input logic rstV, input logic [3:0] reqV, input logic flushV,
                               input logic [127:0] dataV);
    @(posedge clk);
    #1;
    rst            = rstV;
    bus.i_req      = reqV;
    bus.i_flush    = flushV;
    bus.i_req_data = dataV;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [3:0] expG;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.i_req = '0;
    bus.i_flush = 1'b0;
    bus.i_req_data = '0;

    // Reset held two cycles with every client requesting.
    applyStimulus(1'b1, 4'b1111, 1'b0, DataRR);
    checkOutput("rst_gnt0", 64'(bus.o_gnt), 64'h0);
    applyStimulus(1'b1, 4'b1111, 1'b0, DataRR);
    checkOutput("rst_gnt1", 64'(bus.o_gnt), 64'h0);
    checkOutput("rst_issue_valid", 64'(bus.o_issue_valid), 64'h0);
    checkOutput("rst_resp_valid", 64'(bus.o_resp_valid), 64'h0);
    checkOutput("rst_busy", 64'(bus.o_busy), 64'h0);
    applyStimulus(1'b0, 4'b0000, 1'b0, '0);
    checkOutput("post_rst_busy", 64'(bus.o_busy), 64'h0);

    // Single client 2, data 0xA5.
    applyStimulus(1'b0, 4'b0100, 1'b0, DataA5);
    checkOutput("single_gnt", 64'(bus.o_gnt), 64'h4);
    applyStimulus(1'b0, 4'b0000, 1'b0, '0);
    checkOutput("single_issue_valid", 64'(bus.o_issue_valid), 64'h1);
    checkOutput("single_issue_data", 64'(bus.o_issue_data), 64'hA5);
    checkOutput("single_busy", 64'(bus.o_busy), 64'h1);
    for (int c = 2; c <= 8; c++) begin
      applyStimulus(1'b0, 4'b0000, 1'b0, '0);
      checkOutput($sformatf("single_no_resp_c%0d", c), 64'(bus.o_resp_valid), 64'h0);
    end
    applyStimulus(1'b0, 4'b0000, 1'b0, '0);
    checkOutput("single_resp_valid", 64'(bus.o_resp_valid), 64'h1);
    checkOutput("single_resp_id", 64'(bus.o_resp_id), 64'h2);
    checkOutput("single_resp_data", 64'(bus.o_resp_data), 64'hA5);
    applyStimulus(1'b0, 4'b0000, 1'b0, '0);
    checkOutput("single_resp_done", 64'(bus.o_resp_valid), 64'h0);
    checkOutput("single_idle", 64'(bus.o_busy), 64'h0);

    // Mid-run reset brings the pointer back to client 0 for the round-robin run.
    applyStimulus(1'b1, 4'b0000, 1'b0, '0);
    for (int c = 0; c < 18; c++) begin
      applyStimulus(1'b0, (c < 8) ? 4'b1111 : 4'b0000, 1'b0, DataRR);
      expG = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
      checkOutput($sformatf("rr_gnt_c%0d", c), 64'(bus.o_gnt), 64'(expG));
      if (c >= 9 && c <= 16) begin
        checkOutput($sformatf("rr_resp_valid_c%0d", c), 64'(bus.o_resp_valid), 64'h1);
        checkOutput($sformatf("rr_resp_id_c%0d", c), 64'(bus.o_resp_id), 64'((c - 9) % 4));
        checkOutput($sformatf("rr_resp_data_c%0d", c), 64'(bus.o_resp_data), 64'(32'h100 + (c - 9) % 4));
      end else begin
        checkOutput($sformatf("rr_no_resp_c%0d", c), 64'(bus.o_resp_valid), 64'h0);
      end
      if (c == 8) checkOutput("rr_cnt0_mid", 64'(dut.cnt_q[0]), 64'h2);
    end
    checkOutput("rr_idle", 64'(bus.o_busy), 64'h0);
    checkOutput("rr_cnt3_drained", 64'(dut.cnt_q[3]), 64'h0);

    // Client 1 alone: limit of 4 stalls it until its first word returns.
    for (int c = 0; c <= 14; c++) begin
      applyStimulus(1'b0, 4'b0010, 1'b0, Data41);
      expG = (c <= 3 || (c >= 10 && c <= 13)) ? 4'b0010 : 4'b0000;
      checkOutput($sformatf("lim_gnt_c%0d", c), 64'(bus.o_gnt), 64'(expG));
      if (c == 9) begin
        checkOutput("lim_cnt_full", 64'(dut.cnt_q[1]), 64'h4);
        checkOutput("lim_resp_valid", 64'(bus.o_resp_valid), 64'h1);
        checkOutput("lim_resp_id", 64'(bus.o_resp_id), 64'h1);
        checkOutput("lim_resp_data", 64'(bus.o_resp_data), 64'h41);
      end
      if (c == 10) begin
        checkOutput("lim_cnt_after_resp", 64'(dut.cnt_q[1]), 64'h3);
        checkOutput("lim_resp_with_gnt", 64'(bus.o_resp_valid), 64'h1);
      end
      if (c == 11) checkOutput("lim_cnt_gnt_and_resp", 64'(dut.cnt_q[1]), 64'h3);
      if (c == 14) checkOutput("lim_cnt_refull", 64'(dut.cnt_q[1]), 64'h4);
    end

    // Fill the remaining clients, then flush the cycle after a grant to client 0.
    applyStimulus(1'b0, 4'b1111, 1'b0, DataRR);
    checkOutput("fill_gnt2", 64'(bus.o_gnt), 64'h4);
    applyStimulus(1'b0, 4'b1111, 1'b0, DataRR);
    checkOutput("fill_gnt3", 64'(bus.o_gnt), 64'h8);
    applyStimulus(1'b0, 4'b1111, 1'b0, DataRR);
    checkOutput("fill_gnt0", 64'(bus.o_gnt), 64'h1);
    applyStimulus(1'b0, 4'b1111, 1'b1, DataRR);
    checkOutput("flush_gnt", 64'(bus.o_gnt), 64'h0);
    checkOutput("flush_issue_valid_before", 64'(bus.o_issue_valid), 64'h1);
    checkOutput("flush_issue_data", 64'(bus.o_issue_data), 64'h100);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, 4'b0000, 1'b0, '0);
      checkOutput($sformatf("flush_no_resp_%0d", c), 64'(bus.o_resp_valid), 64'h0);
      if (c == 0) begin
        checkOutput("flush_busy", 64'(bus.o_busy), 64'h0);
        checkOutput("flush_issue_valid", 64'(bus.o_issue_valid), 64'h0);
        checkOutput("flush_cnt0", 64'(dut.cnt_q[0]), 64'h0);
        checkOutput("flush_cnt1", 64'(dut.cnt_q[1]), 64'h0);
        checkOutput("flush_cnt2", 64'(dut.cnt_q[2]), 64'h0);
        checkOutput("flush_cnt3", 64'(dut.cnt_q[3]), 64'h0);
      end
    end

    // Pointer survived the flush: it still points at client 1.
    applyStimulus(1'b0, 4'b1111, 1'b0, DataRR);
    checkOutput("post_flush_gnt", 64'(bus.o_gnt), 64'h2);
    applyStimulus(1'b0, 4'b0000, 1'b0, '0);
    checkOutput("post_flush_issue_data", 64'(bus.o_issue_data), 64'h101);
    checkOutput("post_flush_issue_valid", 64'(bus.o_issue_valid), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
